// File: rtl/mealy_pattern_scheduler.sv
// Round-robin scheduler that shares one Mealy switch-pattern detector between
// two requesters, shifting each granted pattern in LSB first and counting out pulses.
module mealy_pattern_scheduler #(
  parameter  int LEN = 8,
  localparam int CW  = $clog2(LEN + 1)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          req_a,
  input  logic [LEN-1:0] pattern_a,
  output logic          gnt_a,
  output logic          done_a,
  input  logic          req_b,
  input  logic [LEN-1:0] pattern_b,
  output logic          gnt_b,
  output logic          done_b,
  output logic [CW-1:0] result,
  output logic          busy,
  output logic          fsm_control,
  output logic          fsm_reset,
  input  logic          fsm_out
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_CLR   = 3'd1;
  localparam logic [2:0] S_SHIFT = 3'd2;
  localparam logic [2:0] S_DRAIN = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  localparam logic [CW-1:0] LAST_BIT = CW'(LEN - 1);

  logic [2:0]     state_q, state_d;
  logic [LEN-1:0] pat_q, pat_d;
  logic [CW-1:0]  bit_q, bit_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [CW-1:0]  result_q, result_d;
  logic           owner_b_q, owner_b_d;
  logic           last_b_q, last_b_d;
  logic           gnt_a_q, gnt_a_d, gnt_b_q, gnt_b_d;
  logic           done_a_q, done_a_d, done_b_q, done_b_d;
  logic           busy_q, busy_d;
  logic           ctl_q, ctl_d;
  logic           frst_q, frst_d;

  always_comb begin
    state_d   = state_q;
    pat_d     = pat_q;
    bit_d     = bit_q;
    cnt_d     = cnt_q;
    result_d  = result_q;
    owner_b_d = owner_b_q;
    last_b_d  = last_b_q;
    gnt_a_d   = 1'b0;
    gnt_b_d   = 1'b0;
    done_a_d  = 1'b0;
    done_b_d  = 1'b0;
    ctl_d     = 1'b0;
    frst_d    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (req_a && (!req_b || last_b_q)) begin
          pat_d     = pattern_a;
          owner_b_d = 1'b0;
          last_b_d  = 1'b0;
          gnt_a_d   = 1'b1;
          frst_d    = 1'b1;
          state_d   = S_CLR;
        end else if (req_b) begin
          pat_d     = pattern_b;
          owner_b_d = 1'b1;
          last_b_d  = 1'b1;
          gnt_b_d   = 1'b1;
          frst_d    = 1'b1;
          state_d   = S_CLR;
        end
      end
      S_CLR: begin
        cnt_d   = '0;
        bit_d   = '0;
        ctl_d   = pat_q[0];
        pat_d   = pat_q >> 1;
        state_d = S_SHIFT;
      end
      S_SHIFT: begin
        // Detector out is registered, so it reflects the previous bit; bit 0 has no result yet.
        if ((bit_q != '0) && fsm_out) cnt_d = cnt_q + CW'(1);
        if (bit_q == LAST_BIT) begin
          state_d = S_DRAIN;
        end else begin
          bit_d = bit_q + CW'(1);
          ctl_d = pat_q[0];
          pat_d = pat_q >> 1;
        end
      end
      S_DRAIN: begin
        if (fsm_out) cnt_d = cnt_q + CW'(1);
        state_d = S_DONE;
      end
      S_DONE: begin
        result_d = cnt_q;
        done_a_d = !owner_b_q;
        done_b_d = owner_b_q;
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      pat_q     <= '0;
      bit_q     <= '0;
      cnt_q     <= '0;
      result_q  <= '0;
      owner_b_q <= 1'b0;
      last_b_q  <= 1'b1;
      gnt_a_q   <= 1'b0;
      gnt_b_q   <= 1'b0;
      done_a_q  <= 1'b0;
      done_b_q  <= 1'b0;
      busy_q    <= 1'b0;
      ctl_q     <= 1'b0;
      frst_q    <= 1'b1;
    end else begin
      state_q   <= state_d;
      pat_q     <= pat_d;
      bit_q     <= bit_d;
      cnt_q     <= cnt_d;
      result_q  <= result_d;
      owner_b_q <= owner_b_d;
      last_b_q  <= last_b_d;
      gnt_a_q   <= gnt_a_d;
      gnt_b_q   <= gnt_b_d;
      done_a_q  <= done_a_d;
      done_b_q  <= done_b_d;
      busy_q    <= busy_d;
      ctl_q     <= ctl_d;
      frst_q    <= frst_d;
    end
  end

  assign gnt_a       = gnt_a_q;
  assign gnt_b       = gnt_b_q;
  assign done_a      = done_a_q;
  assign done_b      = done_b_q;
  assign result      = result_q;
  assign busy        = busy_q;
  assign fsm_control = ctl_q;
  assign fsm_reset   = frst_q;

endmodule

// File: tb/tb_mealy_pattern_scheduler.sv
// Directed bench for mealy_pattern_scheduler with a behavioural detector attached
// to fsm_control/fsm_reset/fsm_out; expected counts are hand-computed.
module tb_mealy_pattern_scheduler;

  logic       clock;
  logic       reset;
  logic       req_a, req_b;
  logic [7:0] pattern_a, pattern_b;
  logic       gnt_a, gnt_b, done_a, done_b;
  logic [3:0] result;
  logic       busy, fsm_control, fsm_reset, fsm_out;

  int total = 0;
  int bad   = 0;

  logic [1:0] ds = 2'd0;
  logic       dout = 1'b0;

  mealy_pattern_scheduler #(.LEN(8)) dut (
    .clock(clock), .reset(reset),
    .req_a(req_a), .pattern_a(pattern_a), .gnt_a(gnt_a), .done_a(done_a),
    .req_b(req_b), .pattern_b(pattern_b), .gnt_b(gnt_b), .done_b(done_b),
    .result(result), .busy(busy),
    .fsm_control(fsm_control), .fsm_reset(fsm_reset), .fsm_out(fsm_out)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Detector per its contract: sync active-high reset, registered out.
  always @(posedge clock) begin
    if (fsm_reset) begin
      ds   <= 2'd0;
      dout <= 1'b0;
    end else begin
      case (ds)
        2'd0: begin ds <= fsm_control ? 2'd1 : 2'd0; dout <= fsm_control; end
        2'd1: begin ds <= fsm_control ? 2'd1 : 2'd2; dout <= 1'b0; end
        2'd2: begin ds <= fsm_control ? 2'd3 : 2'd2; dout <= fsm_control; end
        default: begin ds <= fsm_control ? 2'd0 : 2'd3; dout <= 1'b0; end
      endcase
    end
  end
  assign fsm_out = dout;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  always @(negedge clock) begin
    chk("gnt_onehot", {31'd0, gnt_a & gnt_b}, 32'd0);
    chk("done_onehot", {31'd0, done_a & done_b}, 32'd0);
  end

  // One operation starting from IDLE with the requests already set by the caller.
  task automatic op(input bit who_b, input logic [7:0] pat, input int exp_res,
                    input int drop_at, input bit glitch, input bit scramble);
    tick();
    chk("gnt_own",   who_b ? gnt_b : gnt_a, 1);
    chk("gnt_other", who_b ? gnt_a : gnt_b, 0);
    chk("busy_gnt",  busy, 1);
    chk("frst_clr",  fsm_reset, 1);
    chk("ctl_clr",   fsm_control, 0);
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("ctl_bit",    fsm_control, pat[i]);
      chk("frst_shift", fsm_reset, 0);
      chk("gnt_shift",  {gnt_a, gnt_b}, 0);
      chk("done_shift", {done_a, done_b}, 0);
      if (i == drop_at) begin
        if (who_b) req_b = 1'b0; else req_a = 1'b0;
      end
      if (glitch && i == 2) begin
        if (who_b) req_a = 1'b1; else req_b = 1'b1;
      end
      if (glitch && i == 3) begin
        if (who_b) req_a = 1'b0; else req_b = 1'b0;
      end
      if (scramble && i == 3) begin
        pattern_a = ~pattern_a;
        pattern_b = ~pattern_b;
      end
    end
    tick();
    chk("ctl_drain",  fsm_control, 0);
    chk("done_drain", {done_a, done_b}, 0);
    tick();
    chk("done_early", {done_a, done_b}, 0);
    chk("busy_done",  busy, 1);
    tick();
    chk("done_own",   who_b ? done_b : done_a, 1);
    chk("done_other", who_b ? done_a : done_b, 0);
    chk("result",     result, exp_res);
    chk("busy_idle",  busy, 0);
  endtask

  initial begin
    reset = 1'b0;
    req_a = 1'b0; req_b = 1'b0;
    pattern_a = 8'h00; pattern_b = 8'h00;
    tick(); tick();
    chk("rst_gnt",    {gnt_a, gnt_b}, 0);
    chk("rst_done",   {done_a, done_b}, 0);
    chk("rst_result", result, 0);
    chk("rst_busy",   busy, 0);
    chk("rst_ctl",    fsm_control, 0);
    chk("rst_frst",   fsm_reset, 1);
    reset = 1'b1;
    tick();
    chk("idle_frst", fsm_reset, 0);
    chk("idle_busy", busy, 0);

    // A alone
    pattern_a = 8'h0D; req_a = 1'b1;
    op(1'b0, 8'h0D, 2, -1, 1'b0, 1'b0);
    req_a = 1'b0;
    tick();
    chk("result_hold", result, 2);
    chk("done_clear",  done_a, 0);

    // B alone, three patterns
    pattern_b = 8'hFF; req_b = 1'b1;
    op(1'b1, 8'hFF, 1, -1, 1'b0, 1'b0);
    req_b = 1'b0; tick();
    pattern_b = 8'h00; req_b = 1'b1;
    op(1'b1, 8'h00, 0, -1, 1'b0, 1'b0);
    req_b = 1'b0; tick();
    pattern_b = 8'hAA; req_b = 1'b1;
    op(1'b1, 8'hAA, 3, -1, 1'b0, 1'b0);
    req_b = 1'b0; tick();

    // Reset in the middle of SHIFT
    pattern_a = 8'h0D; req_a = 1'b1;
    tick();
    chk("gnt_pre_rst", gnt_a, 1);
    repeat (4) tick();
    reset = 1'b0;
    req_a = 1'b0;
    #1;
    chk("midrst_busy", busy, 0);
    chk("midrst_frst", fsm_reset, 1);
    tick();
    chk("midrst_busy2", busy, 0);
    chk("midrst_frst2", fsm_reset, 1);
    for (int k = 0; k < 10; k++) begin
      tick();
      chk("midrst_nodone", {done_a, done_b}, 0);
    end
    reset = 1'b1;
    tick();
    req_a = 1'b1;
    op(1'b0, 8'h0D, 2, -1, 1'b0, 1'b0);
    req_a = 1'b0;
    tick();

    // Simultaneous requests from reset: A first, then B one cycle after done_a
    reset = 1'b0; tick();
    reset = 1'b1; tick();
    pattern_a = 8'h33; pattern_b = 8'h55;
    req_a = 1'b1; req_b = 1'b1;
    op(1'b0, 8'h33, 2, -1, 1'b0, 1'b0);
    req_a = 1'b0;
    op(1'b1, 8'h55, 3, -1, 1'b0, 1'b0);
    // Both held continuously: alternate A,B,A,B
    pattern_a = 8'h5A; pattern_b = 8'hF0; req_a = 1'b1;
    op(1'b0, 8'h5A, 3, -1, 1'b0, 1'b0);
    op(1'b1, 8'hF0, 1, -1, 1'b0, 1'b0);
    op(1'b0, 8'h5A, 3, -1, 1'b0, 1'b0);
    op(1'b1, 8'hF0, 1, -1, 1'b0, 1'b0);
    req_a = 1'b0; req_b = 1'b0;
    tick();

    // A pulsed while B busy: never granted
    pattern_b = 8'hAA; req_b = 1'b1;
    op(1'b1, 8'hAA, 3, -1, 1'b1, 1'b0);
    req_b = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("glitch_no_gnt", gnt_a, 0);
      chk("glitch_idle",   busy, 0);
    end

    // A dropped mid-SHIFT after grant still completes
    pattern_a = 8'h0F; req_a = 1'b1;
    op(1'b0, 8'h0F, 1, 4, 1'b0, 1'b0);
    tick();
    chk("drop_no_regnt", gnt_a, 0);

    // Pattern changed mid-operation has no effect
    pattern_a = 8'h55; req_a = 1'b1;
    op(1'b0, 8'h55, 3, -1, 1'b0, 1'b1);
    req_a = 1'b0;
    tick();
    chk("final_idle", busy, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
